// File: rtl/vedic_pkg.sv
// Shared definitions for the vedic multiplier and the multiply-accumulate stage.
package vedic_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  // Largest product of two 4-bit operands (15*15).
  localparam logic [PROD_W-1:0] MAX_PROD = 8'd225;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_t;

endpackage

// File: rtl/vedicmult_4bit.sv
// 4x4 unsigned Vedic (Urdhva Tiryagbhyam) multiplier built from four 2x2 blocks.
module vedicmult_4bit
  import vedic_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [PROD_W-1:0] prod_o
);

  // 2x2 vertical-and-crosswise block: gate-level partial products and carries.
  function automatic logic [3:0] vm2(input logic [1:0] a, input logic [1:0] b);
    logic c1;
    c1  = (a[1] & b[0]) & (a[0] & b[1]);
    vm2 = {(a[1] & b[1]) & c1,
           (a[1] & b[1]) ^ c1,
           (a[1] & b[0]) ^ (a[0] & b[1]),
           a[0] & b[0]};
  endfunction

  logic [3:0] q0_s;
  logic [3:0] q1_s;
  logic [3:0] q2_s;
  logic [3:0] q3_s;

  assign q0_s = vm2(a_i[1:0], b_i[1:0]);
  assign q1_s = vm2(a_i[3:2], b_i[1:0]);
  assign q2_s = vm2(a_i[1:0], b_i[3:2]);
  assign q3_s = vm2(a_i[3:2], b_i[3:2]);

  assign prod_o = {4'd0, q0_s} + {2'd0, q1_s, 2'd0} + {2'd0, q2_s, 2'd0} + {q3_s, 4'd0};

endmodule

// File: rtl/vedic_mac_4bit.sv
// Multiply-accumulate stage: LEN products summed into one dot-product result.
// Define VEDIC_MAC_SAT_EN to saturate the accumulator on carry-out instead of wrapping.
module vedic_mac_4bit
  import vedic_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam logic [7:0] LEN_C = 8'(LEN);

  mac_state_t       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] prod_q, prod_d;
  logic             prod_v_q, prod_v_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [PROD_W-1:0] mult_s;
  logic [ACC_W:0]    sum_s;
  logic              accept_s;

  vedicmult_4bit u_mult (
    .a_i    (in_a),
    .b_i    (in_b),
    .prod_o (mult_s)
  );

  assign accept_s = in_valid && in_ready_q;
  assign sum_s    = {1'b0, acc_q} + {1'b0, prod_q};

  // Next-state, accumulator and handshake decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    prod_d   = prod_q;
    prod_v_d = 1'b0;

    if (prod_v_q) begin
      ovf_d = ovf_q | sum_s[ACC_W];
`ifdef VEDIC_MAC_SAT_EN
      // Once saturated, any further non-zero product carries again, so all-ones holds.
      if (sum_s[ACC_W]) begin
        acc_d = {ACC_W{1'b1}};
      end else begin
        acc_d = sum_s[ACC_W-1:0];
      end
`else
      acc_d = sum_s[ACC_W-1:0];
`endif
    end else begin
      acc_d = acc_q;
    end

    if (accept_s) begin
      prod_d   = ACC_W'(mult_s);
      prod_v_d = 1'b1;
      cnt_d    = cnt_q + 8'd1;
    end else begin
      prod_v_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = (LEN_C == 8'd1) ? DRAIN : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s && (cnt_d == LEN_C)) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = {ACC_W{1'b0}};
          cnt_d   = 8'd0;
          ovf_d   = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE) || (state_d == RUN);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      acc_q       <= {ACC_W{1'b0}};
      prod_q      <= {ACC_W{1'b0}};
      prod_v_q    <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      prod_v_q    <= prod_v_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_vedic_mac_4bit.sv
// Self-checking bench for vedic_mac_4bit: four instances with different LEN/ACC_W.
module tb_vedic_mac_4bit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance index: 0 = LEN4/ACC16, 1 = LEN2/ACC8, 2 = LEN1/ACC16, 3 = LEN3/ACC16.
  logic        in_valid [4];
  logic        in_ready [4];
  logic [3:0]  in_a     [4];
  logic [3:0]  in_b     [4];
  logic        out_valid[4];
  logic        out_ready[4];
  logic        out_ovf  [4];
  logic [15:0] out_acc  [4];
  logic [15:0] acc0_s, acc2_s, acc3_s;
  logic [7:0]  acc1_s;

  assign out_acc[0] = acc0_s;
  assign out_acc[1] = {8'd0, acc1_s};
  assign out_acc[2] = acc2_s;
  assign out_acc[3] = acc3_s;

  vedic_mac_4bit #(.ACC_W(16), .LEN(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_acc(acc0_s), .out_ovf(out_ovf[0]));
  vedic_mac_4bit #(.ACC_W(8), .LEN(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_acc(acc1_s), .out_ovf(out_ovf[1]));
  vedic_mac_4bit #(.ACC_W(16), .LEN(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_acc(acc2_s), .out_ovf(out_ovf[2]));
  vedic_mac_4bit #(.ACC_W(16), .LEN(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_a(in_a[3]), .in_b(in_b[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_acc(acc3_s), .out_ovf(out_ovf[3]));

  int tests = 0;
  int fails = 0;

  typedef struct {
    int             d;
    int             n;
    logic [3:0][3:0] av;
    logic [3:0][3:0] bv;
    int             eacc;
    bit             eovf;
  } vec_t;

`ifdef VEDIC_MAC_SAT_EN
  localparam int OVF8_ACC = 255;
`else
  localparam int OVF8_ACC = 194;
`endif

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the true unsigned sum, then wrapped or clamped to the result width.
  function automatic int model_acc(input int sum, input int accw);
    longint lim;
    lim = longint'(1) << accw;
`ifdef VEDIC_MAC_SAT_EN
    model_acc = (sum >= lim) ? int'(lim - 1) : sum;
`else
    model_acc = int'(longint'(sum) % lim);
`endif
  endfunction

  function automatic bit model_ovf(input int sum, input int accw);
    model_ovf = longint'(sum) >= (longint'(1) << accw);
  endfunction

  // Presents one beat after `gap` idle cycles and waits for it to be accepted.
  task automatic send(input int d, input int a, input int b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid[d] = 1'b1;
    in_a[d] = 4'(a);
    in_b[d] = 4'(b);
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = in_ready[d];
      @(negedge clk);
    end
    in_valid[d] = 1'b0;
    check("accept", ok, 1);
  endtask

  // Waits for out_valid, checks the result, optionally stalls, then completes the handshake.
  task automatic get_result(input int d, input int hold, input int eacc, input bit eovf,
                            input string name);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      seen = out_valid[d];
      if (!seen) @(negedge clk);
    end
    check({name, "_valid"}, seen, 1);
    check({name, "_acc"}, out_acc[d], eacc);
    check({name, "_ovf"}, out_ovf[d], eovf);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "_hold_acc"}, out_acc[d], eacc);
      check({name, "_hold_valid"}, out_valid[d], 1);
      check({name, "_hold_ready"}, in_ready[d], 0);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    check({name, "_valid_fall"}, out_valid[d], 0);
    check({name, "_idle_ready"}, in_ready[d], 1);
    check({name, "_clear_ovf"}, out_ovf[d], 0);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{0, 4, {4'd7, 4'd0, 4'd15, 4'd3}, {4'd2, 4'd9, 4'd15, 4'd5}, 254, 1'b0};
    vecs[1] = '{1, 2, {4'd0, 4'd0, 4'd15, 4'd15}, {4'd0, 4'd0, 4'd15, 4'd15}, OVF8_ACC, 1'b1};
    vecs[2] = '{1, 2, {4'd0, 4'd0, 4'd1, 4'd1}, {4'd0, 4'd0, 4'd1, 4'd1}, 2, 1'b0};
    vecs[3] = '{3, 3, {4'd0, 4'd6, 4'd4, 4'd2}, {4'd0, 4'd7, 4'd5, 4'd3}, 68, 1'b0};

    for (int i = 0; i < 4; i++) begin
      in_valid[i] = 1'b0; in_a[i] = 4'd0; in_b[i] = 4'd0; out_ready[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("reset_in_ready", in_ready[i], 1);
      check("reset_out_valid", out_valid[i], 0);
      check("reset_out_acc", out_acc[i], 0);
      check("reset_out_ovf", out_ovf[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back beats with cycle-exact latency on the last one.
    out_ready[0] = 1'b1;
    send(0, 3, 5, 0);
    send(0, 15, 15, 0);
    send(0, 0, 9, 0);
    check("lat_ready_before_last", in_ready[0], 1);
    in_valid[0] = 1'b1; in_a[0] = 4'd7; in_b[0] = 4'd2;
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("lat_drain_valid", out_valid[0], 0);
    check("lat_drain_ready", in_ready[0], 0);
    @(negedge clk);
    check("lat_done_valid", out_valid[0], 1);
    check("lat_done_acc", out_acc[0], 254);
    check("lat_done_ovf", out_ovf[0], 0);
    @(negedge clk);
    check("lat_one_cycle", out_valid[0], 0);
    check("lat_back_idle", in_ready[0], 1);

    // Gaps between beats and a stalled consumer.
    out_ready[0] = 1'b0;
    send(0, 3, 5, 0);
    send(0, 15, 15, 0);
    send(0, 0, 9, 3);
    send(0, 7, 2, 1);
    check("gap_drain_ready", in_ready[0], 0);
    get_result(0, 5, 254, 1'b0, "gap");
    out_ready[0] = 1'b0;

    // Table of fixed vectors, including the 8-bit overflow case and its follow-up.
    for (int v = 0; v < 4; v++) begin
      out_ready[vecs[v].d] = 1'b0;
      for (int k = 0; k < vecs[v].n; k++) begin
        send(vecs[v].d, int'(vecs[v].av[k]), int'(vecs[v].bv[k]), 0);
      end
      get_result(vecs[v].d, 1, vecs[v].eacc, vecs[v].eovf, $sformatf("vec%0d", v));
      out_ready[vecs[v].d] = 1'b0;
    end

    // Reset mid-dot-product discards the partial sum.
    send(0, 9, 9, 0);
    send(0, 8, 8, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", in_ready[0], 1);
    check("rst_mid_out_valid", out_valid[0], 0);
    check("rst_mid_out_acc", out_acc[0], 0);
    check("rst_mid_out_ovf", out_ovf[0], 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) send(0, 1, 2, 0);
    get_result(0, 0, 8, 1'b0, "rst_after");
    out_ready[0] = 1'b0;

    // LEN=1: every operand pair in a shuffled-gap order.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        send(2, a, b, int'($urandom_range(0, 1)));
        get_result(2, 0, a * b, 1'b0, "len1");
        out_ready[2] = 1'b0;
      end
    end

    // Random dot products on the wide and the narrow instance.
    for (int r = 0; r < 40; r++) begin
      int d, n, w, sum, a, b;
      d = (r % 2 == 0) ? 0 : 1;
      n = (d == 0) ? 4 : 2;
      w = (d == 0) ? 16 : 8;
      sum = 0;
      for (int k = 0; k < n; k++) begin
        a = int'($urandom_range(0, 15));
        b = int'($urandom_range(0, 15));
        sum += a * b;
        send(d, a, b, int'($urandom_range(0, 2)));
      end
      get_result(d, int'($urandom_range(0, 3)), model_acc(sum, w), model_ovf(sum, w), "rand");
      out_ready[d] = 1'b0;
    end

    // LEN=3 with in_valid held high through DRAIN/DONE.
    begin
      int a, b, cnt, sum, results;
      int expq[$];
      cnt = 0; sum = 0; results = 0;
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      out_ready[3] = 1'b1;
      in_valid[3] = 1'b1; in_a[3] = 4'(a); in_b[3] = 4'(b);
      for (int t = 0; t < 60; t++) begin
        bit acc_now;
        acc_now = in_ready[3];
        if (out_valid[3]) begin
          results++;
          check("stream_ready_low", in_ready[3], 0);
          if (expq.size() > 0) begin
            check("stream_acc", out_acc[3], expq.pop_front());
          end else begin
            check("stream_unexpected_result", 1, 0);
          end
        end
        if (acc_now) begin
          sum += a * b;
          cnt++;
          if (cnt == 3) begin
            expq.push_back(sum);
            cnt = 0; sum = 0;
          end
        end
        @(negedge clk);
        if (acc_now) begin
          a = int'($urandom_range(0, 15));
          b = int'($urandom_range(0, 15));
          in_a[3] = 4'(a); in_b[3] = 4'(b);
        end
      end
      in_valid[3] = 1'b0;
      check("stream_results", results >= 10, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
